tpu_instr_sequencer: RTL and testbench
======================================

// Module: tpu_instr_sequencer
// PURPOSE
// Decodes the 16-bit TPU instruction stream (opcode[15:13], imm[12:0]) and sequences the datapath:
// weight load, input-setup load, systolic compute window and accumulator store to unified buffer.
// Sits between the host/instruction source and the MMU/unified buffer.
// Owns the base-address register and times the compute/drain window, so the host stops padding idle cycles.
// PARAMETERS
// INSTR_W        16  instruction width
// IMM_W          13  immediate / base-address width
// COMPUTE_CYCLES 6   cycles compute_en stays high per COMPUTE: 1 setup + 3 skewed feed + 2 drain, for the 2x2 array
// CNT_W          3   compute counter width; must hold COMPUTE_CYCLES-1
// PORTS
// clk            in   1        rising-edge clock
// reset          in   1        synchronous, active-high
// instr_valid    in   1        host presents instr this cycle
// instr          in   INSTR_W  instruction word
// instr_ready    out  1        sequencer accepts instr this cycle
// base_addr      out  IMM_W    current base address for weight/input/store accesses
// load_weight_en out  1        1-cycle strobe: weight memory -> MMU from base_addr
// load_input_en  out  1        1-cycle strobe: unified buffer -> input setup from base_addr
// compute_en     out  1        high for the whole compute window
// store_en       out  1        1-cycle strobe: accumulator rows -> unified buffer at base_addr
// busy           out  1        high whenever state != IDLE
// halted         out  1        high in HALTED
// illegal_op     out  1        1-cycle pulse on an accepted reserved opcode
// BEHAVIOUR
// - Opcodes:
//   000 NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUT, 100 COMPUTE, 101 STORE, 110 reserved, 111 HALT.
// - States:
//   IDLE -(accept COMPUTE)-> COMPUTE -(cnt==0)-> IDLE
//   IDLE -(accept HALT)-> HALTED (exit only by reset).
// - Handshake:
//   - Accept when instr_valid && instr_ready.
//   - instr_ready = (state==IDLE) && !reset, combinational.
//   - instr is ignored when not accepted.
// - Accept in cycle t: all effects are registered and visible at t+1.
//   - LOAD_ADDR: base_addr <= imm.
//   - LOAD_WEIGHT / LOAD_INPUT / STORE: the matching strobe is high for cycle t+1 only.
//   - COMPUTE:
//     - cnt <= COMPUTE_CYCLES-1.
//     - compute_en high for cycles t+1..t+COMPUTE_CYCLES.
//     - In COMPUTE, cnt decrements each cycle; at cnt==0 next state is IDLE.
//     - instr_ready is low t+1..t+COMPUTE_CYCLES and high again at t+COMPUTE_CYCLES+1.
//   - NOP: no output change.
//   - 110: illegal_op high at t+1, otherwise treated as NOP.
//   - HALT: halted and busy high from t+1; instr_ready low forever.
// - Back-to-back accepts in IDLE:
//   - One instruction per cycle, no bubbles.
//   - Consecutive strobe instructions yield strobes on consecutive cycles.
// - base_addr:
//   - Changes only on LOAD_ADDR and holds through all other opcodes, including COMPUTE and HALT.
//   - Only the low 6 bits are meaningful to the 64-entry buffer; no range check is done here.
// - Reset (synchronous, any state, including mid-COMPUTE):
//   - Next edge: state=IDLE, cnt=0, base_addr=0.
//   - All strobes, compute_en, busy, halted and illegal_op = 0.
//   - instr_ready is 0 during reset and 1 in the first cycle after reset deasserts.
// - At most one strobe output is high in any cycle; compute_en is never high together with a strobe.
// STRUCTURE
// - Shared package tpu_pkg:
//   - INSTR_W, OPC_W=3, IMM_W.
//   - typedef enum logic [2:0] opcode_t {OP_NOP, OP_LOAD_ADDR, OP_LOAD_WEIGHT, OP_LOAD_INPUT, OP_COMPUTE, OP_STORE, OP_RSVD, OP_HALT}.
//   - typedef enum seq_state_t {S_IDLE, S_COMPUTE, S_HALTED}.
// - One sub-module: tpu_seq_timer, a loadable down-counter with a done flag, driving the compute window.
// - FSM, decode and base-address register live in this module.
// TESTING
// - Reset then LOAD_ADDR 0x000F, LOAD_WEIGHT back-to-back
//   -> base_addr=15 at t+1; load_weight_en high exactly one cycle at t+2; instr_ready never drops.
// - LOAD_ADDR 0x001E, LOAD_INPUT, COMPUTE with instr_valid held high
//   -> compute_en high exactly 6 cycles; instr_ready low the same 6 cycles.
//   -> The instruction held on instr during the window is accepted on the 7th cycle.
// - After COMPUTE: LOAD_ADDR 0x0007, STORE
//   -> store_en pulses once with base_addr=7; the full load/compute/store program needs no idle padding.
// - Opcode 110 then NOP
//   -> illegal_op one-cycle pulse; base_addr and all strobes unchanged.
// - HALT, then LOAD_WEIGHT presented for 10 cycles
//   -> halted=1, instr_ready=0, no strobe; reset restores IDLE with base_addr=0.
// - reset asserted on the 3rd compute cycle
//   -> next edge compute_en=0, busy=0; instr_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: instruction field widths, opcode encoding and
// sequencer state encoding.
package tpu_pkg;

   localparam int INSTR_W = 16;
   localparam int OPC_W   = 3;
   localparam int IMM_W   = 13;

   typedef enum logic [2:0] {
      OP_NOP         = 3'b000,
      OP_LOAD_ADDR   = 3'b001,
      OP_LOAD_WEIGHT = 3'b010,
      OP_LOAD_INPUT  = 3'b011,
      OP_COMPUTE     = 3'b100,
      OP_STORE       = 3'b101,
      OP_RSVD        = 3'b110,
      OP_HALT        = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_COMPUTE = 2'b01,
      S_HALTED  = 2'b10
   } seq_state_t;

endpackage

// File: rtl/tpu_seq_timer.sv
// Loadable down-counter that times the systolic compute/drain window.
// done is high while the count sits at zero.
module tpu_seq_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/tpu_instr_sequencer.sv
// TPU instruction sequencer: decodes the host instruction stream, owns the
// base-address register and drives the load/compute/store controls.
module tpu_instr_sequencer #(
   parameter int INSTR_W        = 16,
   parameter int IMM_W          = 13,
   parameter int COMPUTE_CYCLES = 6,
   parameter int CNT_W          = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [IMM_W-1:0]   base_addr,
   output logic               load_weight_en,
   output logic               load_input_en,
   output logic               compute_en,
   output logic               store_en,
   output logic               busy,
   output logic               halted,
   output logic               illegal_op
);

   import tpu_pkg::*;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES - 1);

   seq_state_t       state;
   seq_state_t       state_nxt;
   opcode_t          opc;
   logic [IMM_W-1:0] imm;
   logic             accept;
   logic             tmr_load;
   logic             tmr_done;
   logic [CNT_W-1:0] tmr_cnt;

   assign opc         = opcode_t'(instr[INSTR_W-1 -: OPC_W]);
   assign imm         = instr[IMM_W-1:0];
   assign instr_ready = (state == S_IDLE) && !reset;
   assign accept      = instr_valid && instr_ready;
   assign tmr_load    = accept && (opc == OP_COMPUTE);

   tpu_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (CNT_LOAD),
      .en       (state == S_COMPUTE),
      .cnt      (tmr_cnt),
      .done     (tmr_done)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept && (opc == OP_COMPUTE)) begin
               state_nxt = S_COMPUTE;
            end else if (accept && (opc == OP_HALT)) begin
               state_nxt = S_HALTED;
            end
         end
         // Last window cycle is the one where the counter has reached zero.
         S_COMPUTE: begin
            if (tmr_done) begin
               state_nxt = S_IDLE;
            end
         end
         S_HALTED: state_nxt = S_HALTED;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         base_addr      <= '0;
         load_weight_en <= 1'b0;
         load_input_en  <= 1'b0;
         store_en       <= 1'b0;
         illegal_op     <= 1'b0;
      end else begin
         state          <= state_nxt;
         load_weight_en <= accept && (opc == OP_LOAD_WEIGHT);
         load_input_en  <= accept && (opc == OP_LOAD_INPUT);
         store_en       <= accept && (opc == OP_STORE);
         illegal_op     <= accept && (opc == OP_RSVD);
         if (accept && (opc == OP_LOAD_ADDR)) begin
            base_addr <= imm;
         end
      end
   end

   assign compute_en = (state == S_COMPUTE);
   assign busy       = (state != S_IDLE);
   assign halted     = (state == S_HALTED);

   logic unused_cnt;
   assign unused_cnt = ^tmr_cnt;

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Scoreboard bench for tpu_instr_sequencer: a behavioural model predicts
// every output each cycle; each test pops and compares its own results.
module tb_tpu_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic [15:0] instr;
   logic        instr_ready;
   logic [12:0] base_addr;
   logic        load_weight_en, load_input_en, compute_en, store_en;
   logic        busy, halted, illegal_op;

   always #5 clk = ~clk;

   tpu_instr_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_ready    (instr_ready),
      .base_addr      (base_addr),
      .load_weight_en (load_weight_en),
      .load_input_en  (load_input_en),
      .compute_en     (compute_en),
      .store_en       (store_en),
      .busy           (busy),
      .halted         (halted),
      .illegal_op     (illegal_op)
   );

   typedef struct packed {
      logic        rdy;
      logic [19:0] outs;
   } exp_t;

   typedef struct packed {
      logic        v;
      logic        r;
      logic [15:0] ins;
   } stim_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   logic        obs_rdy;
   logic [19:0] obs_outs;

   // Reference model state: m_left counts remaining window cycles 6..1.
   int          m_state = 0;
   int          m_left  = 0;
   logic [12:0] m_base  = '0;
   logic        m_lw = 0, m_li = 0, m_st = 0, m_ill = 0;

   function automatic stim_t mk(input logic v, input logic r, input logic [2:0] op, input logic [12:0] imm);
      stim_t s;
      s.v   = v;
      s.r   = r;
      s.ins = {op, imm};
      return s;
   endfunction

   task automatic drive_cycle(input logic v, input logic r, input logic [15:0] ins);
      exp_t e;
      logic acc;
      logic [2:0] op;
      instr_valid = v;
      instr       = ins;
      reset       = r;
      #1;
      obs_rdy = instr_ready;
      e.rdy   = (m_state == 0) && !r;
      op      = ins[15:13];
      acc     = v && (m_state == 0) && !r;
      m_lw = 0; m_li = 0; m_st = 0; m_ill = 0;
      if (r) begin
         m_state = 0;
         m_left  = 0;
         m_base  = '0;
      end else begin
         if (m_state == 1) begin
            if (m_left == 1) m_state = 0;
            else m_left = m_left - 1;
         end
         if (acc) begin
            case (op)
               3'd1: m_base = ins[12:0];
               3'd2: m_lw = 1;
               3'd3: m_li = 1;
               3'd4: begin m_state = 1; m_left = 6; end
               3'd5: m_st = 1;
               3'd6: m_ill = 1;
               3'd7: m_state = 2;
               default: ;
            endcase
         end
      end
      e.outs = {m_base, m_lw, m_li, (m_state == 1), m_st, (m_state != 0), (m_state == 2), m_ill};
      sb.push_back(e);
      @(posedge clk);
      #1;
      obs_outs = {base_addr, load_weight_en, load_input_en, compute_en, store_en, busy, halted, illegal_op};
      @(negedge clk);
   endtask

   task automatic test_reset();
      stim_t s[$];
      exp_t  e;
      for (int i = 0; i < 3; i++) s.push_back(mk(1'b1, 1'b1, 3'd2, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL reset cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL reset cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_load_weight();
      stim_t s[$];
      exp_t  e;
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h000F));
      s.push_back(mk(1'b1, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL load_weight cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL load_weight cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_compute();
      stim_t s[$];
      exp_t  e;
      int    ce_cnt = 0;
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h001E));
      s.push_back(mk(1'b1, 1'b0, 3'd3, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd4, 13'h0));
      // LOAD_WEIGHT held through the window, accepted on the 7th cycle
      for (int i = 0; i < 7; i++) s.push_back(mk(1'b1, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         if (obs_outs[4]) ce_cnt++;
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL compute cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL compute cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
      checks++;
      if (ce_cnt !== 6) begin
         errors++;
         $display("FAIL compute_window_len got %0d expected %0d", ce_cnt, 6);
      end
   endtask

   task automatic test_store();
      stim_t s[$];
      exp_t  e;
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h0007));
      s.push_back(mk(1'b1, 1'b0, 3'd5, 13'h1FFF));
      s.push_back(mk(1'b0, 1'b0, 3'd5, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL store cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL store cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_illegal();
      stim_t s[$];
      exp_t  e;
      s.push_back(mk(1'b1, 1'b0, 3'd6, 13'h0ABC));
      s.push_back(mk(1'b1, 1'b0, 3'd0, 13'h1234));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL illegal cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL illegal cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$];
      exp_t  e;
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h0021));
      s.push_back(mk(1'b1, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd3, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd5, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h1FC0));
      s.push_back(mk(1'b1, 1'b0, 3'd4, 13'h0055));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL back_to_back cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL back_to_back cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_halt();
      stim_t s[$];
      exp_t  e;
      for (int i = 0; i < 8; i++) s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h0019));
      s.push_back(mk(1'b1, 1'b0, 3'd7, 13'h0));
      for (int i = 0; i < 10; i++) s.push_back(mk(1'b1, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b1, 1'b1, 3'd2, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd3, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL halt cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL halt cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_reset_mid_compute();
      stim_t s[$];
      exp_t  e;
      s.push_back(mk(1'b1, 1'b0, 3'd1, 13'h0033));
      s.push_back(mk(1'b1, 1'b0, 3'd4, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      s.push_back(mk(1'b1, 1'b1, 3'd2, 13'h0));
      s.push_back(mk(1'b1, 1'b0, 3'd2, 13'h0));
      s.push_back(mk(1'b0, 1'b0, 3'd0, 13'h0));
      for (int i = 0; i < s.size(); i++) begin
         drive_cycle(s[i].v, s[i].r, s[i].ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL reset_mid_compute cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL reset_mid_compute cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   task automatic test_random();
      exp_t        e;
      logic        v, r;
      logic [15:0] ins;
      for (int i = 0; i < 80; i++) begin
         v   = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 24) == 0);
         ins = 16'($urandom);
         if (ins[15:13] == 3'd7 && $urandom_range(0, 3) != 0) ins[15:13] = 3'd0;
         drive_cycle(v, r, ins);
         e = sb.pop_front();
         checks++;
         if (obs_outs !== e.outs) begin
            errors++;
            $display("FAIL random cyc%0d outs got %h expected %h", i, obs_outs, e.outs);
         end
         checks++;
         if (obs_rdy !== e.rdy) begin
            errors++;
            $display("FAIL random cyc%0d instr_ready got %b expected %b", i, obs_rdy, e.rdy);
         end
      end
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      @(negedge clk);
      test_reset();
      test_load_weight();
      test_compute();
      test_store();
      test_illegal();
      test_back_to_back();
      test_halt();
      test_reset_mid_compute();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
